// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/subtract unit with valid pipeline and output stall.
// Ports: clk, rst, in_valid/in_ready, A, B, Cin, Sub,
//        out_valid/out_ready, Sum, Cout, Ovf.
module pipelined_addsub #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int W = N / STAGES;

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad
    $error("pipelined_addsub: N must be divisible by STAGES");
  end

  logic         adv;
  logic [N-1:0] beff;
  logic         c0;
  logic         ovf_q;

  assign beff = Sub ? ~B : B;
  assign c0   = Sub ? ~Cin : Cin;

  // One chunk of the carry chain per stage. Operand bits not yet
  // consumed ride along LSB-aligned in g_sk; finished sum chunks
  // accumulate in s_q, growing by W bits per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam bit LAST = (k == STAGES - 1);

    logic [W-1:0]       a_ch;
    logic [W-1:0]       b_ch;
    logic               c_in;
    logic               v_in;
    logic [W:0]         r;
    logic [(k+1)*W-1:0] s_d;
    logic [(k+1)*W-1:0] s_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_first
      assign a_ch = A[W-1:0];
      assign b_ch = beff[W-1:0];
      assign c_in = c0;
      assign v_in = in_valid;
      assign s_d  = r[W-1:0];
    end else begin : g_next
      assign a_ch = g_st[k-1].g_sk.a_q[W-1:0];
      assign b_ch = g_st[k-1].g_sk.b_q[W-1:0];
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign s_d  = {r[W-1:0], g_st[k-1].s_q};
    end

    assign r = {1'b0, a_ch} + {1'b0, b_ch}
             + {{W{1'b0}}, c_in};

    // The last stage only loads real results, so the
    // outputs hold their previous value across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (!LAST || v_in) begin
          c_q <= r[W];
          s_q <= s_d;
        end
      end
    end

    if (!LAST) begin : g_sk
      localparam int SW = N - (k + 1) * W;
      logic [SW-1:0] a_q;
      logic [SW-1:0] b_q;
      logic [SW-1:0] a_d;
      logic [SW-1:0] b_d;

      if (k == 0) begin : g_src
        assign a_d = A[N-1:W];
        assign b_d = beff[N-1:W];
      end else begin : g_src
        assign a_d = g_st[k-1].g_sk.a_q[N-k*W-1:W];
        assign b_d = g_st[k-1].g_sk.b_q[N-k*W-1:W];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_ovf
      // Top chunk carries both sign bits and the result sign.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q <= (a_ch[W-1] == b_ch[W-1])
                && (r[W-1] != a_ch[W-1]);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign Sum       = g_st[STAGES-1].s_q;
  assign Cout      = g_st[STAGES-1].c_q;
  assign Ovf       = ovf_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

endmodule
